// File: rtl/alu3_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, flag-byte bit positions and the captured-control payload.
package alu3_muldiv_pkg;

  localparam int unsigned FLAG_W = 8;

  // Flag byte bit positions
  localparam int unsigned CIDX = 0;
  localparam int unsigned ZIDX = 1;
  localparam int unsigned SIDX = 2;
  localparam int unsigned VIDX = 3;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  // Per-operation control captured at start
  typedef struct packed {
    md_op_e            op;
    logic              sgn;
    logic              neg_res;
    logic              neg_rem;
    logic              ovf;
    logic [FLAG_W-1:0] fi;
  } md_ctrl_t;

  // Incoming flag byte with Z/S/V replaced; carry and spare bits pass through
  function automatic logic [FLAG_W-1:0] merge_flags(
    input logic [FLAG_W-1:0] fi,
    input logic              z,
    input logic              s,
    input logic              v
  );
    logic [FLAG_W-1:0] f;
    f       = fi;
    f[CIDX] = fi[CIDX];
    f[ZIDX] = z;
    f[SIDX] = s;
    f[VIDX] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu3_muldiv_adder.sv
// Plain ripple-style adder used for the per-cycle add/subtract step.
module alu3_muldiv_adder #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c
);

  assign sum_c = a + b + WIDTH'(cin);

endmodule

// File: rtl/alu3_muldiv.sv
// Iterative multiply/divide unit sharing one shift-add / shift-subtract datapath.
// Result and flag byte are registered and qualified by a one-cycle done pulse.
module alu3_muldiv
  import alu3_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              sgn,
  input  logic [WIDTH-1:0]  di,
  input  logic [WIDTH-1:0]  bi,
  input  logic [FLAG_W-1:0] fi,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  res,
  output logic [FLAG_W-1:0] fo
);

  localparam int unsigned AW    = WIDTH + 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e         state, state_n;
  logic [WIDTH-1:0]  acc, acc_n;
  logic [WIDTH-1:0]  mq, mq_n;
  logic [WIDTH-1:0]  bq, bq_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  md_ctrl_t          ctrl, ctrl_n;
  logic              done_n;
  logic [WIDTH-1:0]  res_n;
  logic [FLAG_W-1:0] fo_n;

  logic [AW-1:0]     add_a, add_b, add_sum_c;
  logic              add_cin;

  logic              di_neg, bi_neg, div0, ovf_in, ge;
  logic [WIDTH-1:0]  abs_di, abs_bi, quo, rem, r;
  logic [PW-1:0]     pm, prod;
  logic              v;

  // Divide: trial-subtract divisor from shifted partial remainder.
  // Multiply: conditionally add multiplicand to the upper product half.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (ctrl.op[1]) begin
      add_a   = {acc, mq[WIDTH-1]};
      add_b   = ~{1'b0, bq};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc};
      add_b   = mq[0] ? {1'b0, bq} : '0;
      add_cin = 1'b0;
    end
  end

  alu3_muldiv_adder #(
    .WIDTH(AW)
  ) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum_c(add_sum_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    acc_n   = acc;
    mq_n    = mq;
    bq_n    = bq;
    cnt_n   = cnt;
    ctrl_n  = ctrl;
    done_n  = 1'b0;
    res_n   = res;
    fo_n    = fo;

    di_neg  = sgn & di[WIDTH-1];
    bi_neg  = sgn & bi[WIDTH-1];
    abs_di  = di_neg ? (~di + WIDTH'(1)) : di;
    abs_bi  = bi_neg ? (~bi + WIDTH'(1)) : bi;
    div0    = op[1] & (bi == '0);
    ovf_in  = sgn & op[1] & (di == SMIN) & (&bi);
    ge      = ~add_sum_c[WIDTH];

    pm      = {acc, mq};
    prod    = ctrl.neg_res ? (~pm + PW'(1)) : pm;
    quo     = ctrl.neg_res ? (~mq + WIDTH'(1)) : mq;
    rem     = ctrl.neg_rem ? (~acc + WIDTH'(1)) : acc;
    r       = '0;
    v       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ctrl_n.op      = md_op_e'(op);
          ctrl_n.sgn     = sgn;
          ctrl_n.neg_res = di_neg ^ bi_neg;
          ctrl_n.neg_rem = di_neg;
          ctrl_n.ovf     = ovf_in;
          ctrl_n.fi      = fi;
          acc_n          = '0;
          mq_n           = abs_di;
          bq_n           = abs_bi;
          cnt_n          = '0;
          if (div0) begin
            // Division by zero bypasses the iteration entirely
            res_n   = (md_op_e'(op) == MD_REM) ? di : '1;
            fo_n    = merge_flags(fi, res_n == '0, res_n[WIDTH-1], 1'b1);
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = CALC;
          end
        end
      end

      CALC: begin
        if (ctrl.op[1]) begin
          acc_n = ge ? add_sum_c[WIDTH-1:0] : {acc[WIDTH-2:0], mq[WIDTH-1]};
          mq_n  = {mq[WIDTH-2:0], ge};
        end else begin
          acc_n = add_sum_c[WIDTH:1];
          mq_n  = {add_sum_c[0], mq[WIDTH-1:1]};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n = FIX;
        end
      end

      FIX: begin
        case (ctrl.op)
          MD_MUL: begin
            r = prod[WIDTH-1:0];
            v = ctrl.sgn ? (prod[PW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                         : (prod[PW-1:WIDTH] != '0);
          end
          MD_MULH: begin
            r = prod[PW-1:WIDTH];
            v = 1'b0;
          end
          MD_DIV: begin
            r = quo;
            v = ctrl.ovf;
          end
          MD_REM: begin
            r = rem;
            v = ctrl.ovf;
          end
          default: begin
            r = '0;
            v = 1'b0;
          end
        endcase
        res_n   = r;
        fo_n    = merge_flags(ctrl.fi, r == '0, r[WIDTH-1], v);
        done_n  = 1'b1;
        state_n = DONE;
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mq    <= '0;
      bq    <= '0;
      cnt   <= '0;
      ctrl  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      fo    <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mq    <= mq_n;
      bq    <= bq_n;
      cnt   <= cnt_n;
      ctrl  <= ctrl_n;
      busy  <= (state_n != IDLE);
      done  <= done_n;
      res   <= res_n;
      fo    <= fo_n;
    end
  end

endmodule

// File: tb/tb_alu3_muldiv.sv
// Directed bench for alu3_muldiv (WIDTH=32): vector table plus reset and
// busy/done-cycle start sequences.
module tb_alu3_muldiv;

  localparam int unsigned W  = 32;
  localparam int          NV = 19;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic         sgn;
  logic [W-1:0] di;
  logic [W-1:0] bi;
  logic [7:0]   fi;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic [7:0]   fo;

  int checks = 0;
  int errors = 0;

  alu3_muldiv #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .sgn  (sgn),
    .di   (di),
    .bi   (bi),
    .fi   (fi),
    .busy (busy),
    .done (done),
    .res  (res),
    .fo   (fo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   f;
    logic [W-1:0] r;
    logic         z;
    logic         s;
    logic         v;
    int           lat;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [1:0] o, input logic sg, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [7:0] f, input logic [W-1:0] r,
                              input logic z, input logic s, input logic v, input int lat);
    vec_t t;
    t.op = o; t.sgn = sg; t.a = a; t.b = b; t.f = f;
    t.r = r; t.z = z; t.s = s; t.v = v; t.lat = lat;
    return t;
  endfunction

  // Flag byte layout: bit0 C, bit1 Z, bit2 S, bit3 V, bits 7:4 spare
  function automatic logic [7:0] exp_fo(input logic [7:0] f, input logic z, input logic s,
                                        input logic v);
    return {f[7:4], v, s, z, f[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after the edge that sampled start; lat counts that edge as 1
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [7:0] f, output int lat);
    @(negedge clk);
    op = o; sgn = sg; di = a; bi = b; fi = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    di = $urandom;
    bi = $urandom;
    fi = 8'($urandom);
    wait_done(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [W-1:0] held;

    vecs[0]  = mk(OP_MUL,  1'b0, 32'h0001_0000, 32'h0001_0000, 8'h00, 32'h0000_0000, 1, 0, 1, 34);
    vecs[1]  = mk(OP_MULH, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 8'h00, 32'hFFFF_FFFF, 0, 1, 0, 34);
    vecs[2]  = mk(OP_MUL,  1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 8'h00, 32'hFFFF_FFF1, 0, 1, 0, 34);
    vecs[3]  = mk(OP_DIV,  1'b0, 32'd100,       32'd7,         8'h00, 32'd14,        0, 0, 0, 34);
    vecs[4]  = mk(OP_REM,  1'b0, 32'd100,       32'd7,         8'h00, 32'd2,         0, 0, 0, 34);
    vecs[5]  = mk(OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,         8'h00, 32'hFFFF_FFFD, 0, 1, 0, 34);
    vecs[6]  = mk(OP_REM,  1'b1, 32'hFFFF_FFF9, 32'd2,         8'h00, 32'hFFFF_FFFF, 0, 1, 0, 34);
    vecs[7]  = mk(OP_DIV,  1'b0, 32'd5,         32'd0,         8'h00, 32'hFFFF_FFFF, 0, 1, 1, 1);
    vecs[8]  = mk(OP_REM,  1'b0, 32'd5,         32'd0,         8'h00, 32'd5,         0, 0, 1, 1);
    vecs[9]  = mk(OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00, 32'h8000_0000, 0, 1, 1, 34);
    vecs[10] = mk(OP_MUL,  1'b0, 32'd2,         32'd3,         8'hF1, 32'd6,         0, 0, 0, 34);
    vecs[11] = mk(OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 32'hFFFF_FFFE, 0, 1, 0, 34);
    vecs[12] = mk(OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 32'h0000_0001, 0, 0, 1, 34);
    vecs[13] = mk(OP_REM,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1, 0, 1, 34);
    vecs[14] = mk(OP_DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 8'h00, 32'hFFFF_FFFD, 0, 1, 0, 34);
    vecs[15] = mk(OP_REM,  1'b1, 32'd7,         32'hFFFF_FFFE, 8'h00, 32'd1,         0, 0, 0, 34);
    vecs[16] = mk(OP_MUL,  1'b1, 32'h4000_0000, 32'd2,         8'h00, 32'h8000_0000, 0, 1, 1, 34);
    vecs[17] = mk(OP_DIV,  1'b0, 32'd0,         32'd3,         8'hFF, 32'h0000_0000, 1, 0, 0, 34);
    vecs[18] = mk(OP_REM,  1'b1, 32'hFFFF_FFFB, 32'd0,         8'h00, 32'hFFFF_FFFB, 0, 1, 1, 1);

    reset = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; di = '0; bi = '0; fi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset res",  64'(res),  64'(0));
    check("reset fo",   64'(fo),   64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].f, lat);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d res", i), 64'(res), 64'(vecs[i].r));
      check($sformatf("v%0d fo", i), 64'(fo),
            64'(exp_fo(vecs[i].f, vecs[i].z, vecs[i].s, vecs[i].v)));
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse", i), 64'(done), 64'(0));
      check($sformatf("v%0d res hold", i), 64'(res), 64'(vecs[i].r));
    end

    // Reset in the middle of CALC
    @(negedge clk);
    op = OP_MUL; sgn = 1'b0; di = 32'd7; bi = 32'd9; fi = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst done", 64'(done), 64'(0));
    check("async rst res",  64'(res),  64'(0));
    check("async rst fo",   64'(fo),   64'(0));
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("no done after reset", 64'(n), 64'(0));

    // Start presented on the first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = OP_MUL; sgn = 1'b0; di = 32'd2; bi = 32'd3; fi = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    check("first start busy", 64'(busy), 64'(1));
    wait_done(lat);
    check("first start latency", 64'(lat), 64'(34));
    check("first start res", 64'(res), 64'(6));
    @(posedge clk); #1;

    // Start while busy and start during the DONE cycle are both ignored
    @(negedge clk);
    op = OP_DIV; sgn = 1'b0; di = 32'd100; bi = 32'd7; fi = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    n = 0;
    while (!done && lat < 100) begin
      if (lat == 6) begin
        start = 1'b1; op = OP_MUL; di = 32'd2; bi = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("busy start latency", 64'(lat), 64'(34));
    check("busy start res", 64'(res), 64'(14));
    held = res;
    start = 1'b1; op = OP_MUL; sgn = 1'b0; di = 32'd2; bi = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("done-cycle start busy", 64'(busy), 64'(0));
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("done-cycle start no done", 64'(n), 64'(0));
    check("done-cycle start res hold", 64'(res), 64'(held));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
